// File: rtl/fetch_decode.sv
// ---------------------------------------------------------------------------
// fetch_decode
//
// Purpose:
//   Single-issue instruction fetch and decode stage. Owns the program
//   counter, fetches one 32-bit word at a time over a variable-latency
//   req/valid instruction-memory interface, decodes it into type, funct3,
//   register indices and a sign-extended immediate, and presents the result
//   under a valid/ready handshake. A taken beq reported by the execute stage
//   at the moment of transfer redirects the PC.
//
//   Fetch and decode never overlap: each instruction costs at least two
//   cycles (one FETCH cycle with the response, one HOLD cycle with transfer).
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   When defined, a FETCH that waits TIMEOUT_CYCLES cycles without a memory
//   response sets the sticky fetch_error flag, drops imem_req and parks the
//   FSM in HALT until reset. When undefined, FETCH waits indefinitely and
//   fetch_error is tied low.
//
// Parameters:
//   RESET_PC        PC loaded by reset (multiple of 4)
//   TIMEOUT_CYCLES  FETCH wait limit (only meaningful with FETCH_TIMEOUT_EN)
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-high reset
//   imem_req      out  fetch request, high while in FETCH
//   imem_addr     out  [31:0] PC of the requested word
//   imem_valid    in   imem_data carries the response this cycle
//   imem_data     in   [31:0] fetched instruction word
//   out_valid     out  decoded instruction is being presented
//   out_ready     in   downstream accepts (transfer = out_valid & out_ready)
//   branch_taken  in   presented beq resolved taken, sampled on transfer
//   tipo          out  [2:0] opcode[6:4]
//   funct3        out  [2:0] instr[14:12]
//   rs1           out  [4:0] instr[19:15]
//   rs2           out  [4:0] instr[24:20]
//   rd            out  [4:0] instr[11:7]
//   imm           out  [31:0] sign-extended immediate
//   out_pc        out  [31:0] PC of the presented instruction
//   out_illegal   out  unsupported opcode
//   fetch_error   out  sticky fetch timeout flag
// ---------------------------------------------------------------------------
module fetch_decode #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        branch_taken,
  output logic [2:0]  tipo,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [31:0] out_pc,
  output logic        out_illegal,
  output logic        fetch_error
);

  // Instruction classes, encoded as opcode[6:4].
  localparam logic [2:0] TIPO_LW   = 3'b000;
  localparam logic [2:0] TIPO_SW   = 3'b010;
  localparam logic [2:0] TIPO_R    = 3'b011;
  localparam logic [2:0] TIPO_BEQ  = 3'b110;

  // HALT only exists when the fetch timeout is built in.
`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10,
    S_HALT  = 2'b11
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10
  } state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;

  logic [2:0]  w_tipo;
  logic        w_illegal;
  logic [31:0] w_imm;
  logic        w_transfer;
  logic        w_takeBranch;
  logic [31:0] w_nextPc;

  // Opcode bits [3:2] do not take part in classification; they are folded
  // here so the intent of leaving them out is explicit.
  logic        w_unusedOpBits;
  assign w_unusedOpBits = ^imem_data[3:2];

  // ------------------------------------------------------------------------
  // Decode of the word currently on imem_data. The result is only captured
  // in FETCH on imem_valid, so this logic can run freely every cycle.
  // Illegal words still report their raw fields but always carry imm=0.
  // ------------------------------------------------------------------------
  assign w_tipo = imem_data[6:4];

  always_comb begin
    w_illegal = 1'b0;
    w_imm     = 32'h0000_0000;
    case (w_tipo)
      TIPO_LW:  w_imm = {{20{imem_data[31]}}, imem_data[31:20]};
      TIPO_SW:  w_imm = {{20{imem_data[31]}}, imem_data[31:25], imem_data[11:7]};
      TIPO_BEQ: w_imm = {{19{imem_data[31]}}, imem_data[31], imem_data[7],
                         imem_data[30:25], imem_data[11:8], 1'b0};
      TIPO_R:   w_imm = 32'h0000_0000;
      default:  w_illegal = 1'b1;
    endcase
    if (imem_data[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end
    if (w_illegal) begin
      w_imm = 32'h0000_0000;
    end
  end

  // ------------------------------------------------------------------------
  // Next-PC selection for the presented instruction. Only a legal beq can
  // redirect; the branch target stays word-aligned because imm[0] is 0.
  // Additions wrap modulo 2^32.
  // ------------------------------------------------------------------------
  assign w_transfer   = out_valid & out_ready;
  assign w_takeBranch = branch_taken & (tipo == TIPO_BEQ) & ~out_illegal;
  assign w_nextPc     = w_takeBranch ? (out_pc + imm) : (out_pc + 32'd4);

`ifdef FETCH_TIMEOUT_EN
  // Timeout counter compares against the last allowed wait cycle so that
  // the error fires on the edge ending the TIMEOUT_CYCLES-th empty FETCH.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_toCount;
`else
  localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
  assign fetch_error = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Main FSM. All interface outputs are registered here so they change only
  // on the clock edge that moves the state:
  //   IDLE  -> FETCH  always, one cycle after reset; any imem_valid seen in
  //                   IDLE belongs to a request abandoned by reset and is
  //                   dropped.
  //   FETCH -> HOLD   on imem_valid, capturing the decoded word and its PC.
  //   HOLD  -> FETCH  on transfer, launching the next request immediately.
  //   FETCH -> HALT   (timeout build only) after too many empty cycles.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      out_valid   <= 1'b0;
      tipo        <= 3'b000;
      funct3      <= 3'b000;
      rs1         <= 5'd0;
      rs2         <= 5'd0;
      rd          <= 5'd0;
      imm         <= 32'h0000_0000;
      out_pc      <= 32'h0000_0000;
      out_illegal <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_toCount   <= 32'd0;
      fetch_error <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state   <= S_FETCH;
          imem_req  <= 1'b1;
          imem_addr <= r_pc;
`ifdef FETCH_TIMEOUT_EN
          r_toCount <= 32'd0;
`endif
        end

        S_FETCH: begin
          if (imem_valid) begin
            tipo        <= w_tipo;
            funct3      <= imem_data[14:12];
            rs1         <= imem_data[19:15];
            rs2         <= imem_data[24:20];
            rd          <= imem_data[11:7];
            imm         <= w_imm;
            out_illegal <= w_illegal;
            out_pc      <= r_pc;
            out_valid   <= 1'b1;
            imem_req    <= 1'b0;
            r_state     <= S_HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_toCount == TO_LAST) begin
            fetch_error <= 1'b1;
            imem_req    <= 1'b0;
            r_state     <= S_HALT;
          end else begin
            r_toCount <= r_toCount + 32'd1;
          end
`endif
        end

        S_HOLD: begin
          if (w_transfer) begin
            r_pc      <= w_nextPc;
            imem_addr <= w_nextPc;
            imem_req  <= 1'b1;
            out_valid <= 1'b0;
            r_state   <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            r_toCount <= 32'd0;
`endif
          end
        end

`ifdef FETCH_TIMEOUT_EN
        S_HALT: begin
          imem_req <= 1'b0;
        end
`endif

        default: begin
          r_state  <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode
//
// Self-checking bench for fetch_decode. A table of fetches (address,
// instruction word, memory latency, stall length, branch outcome, expected
// decode, expected next fetch address) is replayed against a simple memory
// model. Expected decodes are queued when a response is driven and popped
// when out_valid appears. Hand-written sequences cover reset during FETCH
// and HOLD and the fetch timeout behaviour.
// ---------------------------------------------------------------------------
module tb_fetch_decode;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic        branch_taken;
  logic [2:0]  tipo;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic        fetch_error;

  fetch_decode #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_data    (imem_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .branch_taken (branch_taken),
    .tipo         (tipo),
    .funct3       (funct3),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .imm          (imm),
    .out_pc       (out_pc),
    .out_illegal  (out_illegal),
    .fetch_error  (fetch_error)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One fetch: stimulus plus expected decode and expected next address.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          lat;
    int          stall;
    logic        br;
    logic [2:0]  expTipo;
    logic [2:0]  expF3;
    logic [4:0]  expRs1;
    logic [4:0]  expRs2;
    logic [4:0]  expRd;
    logic [31:0] expImm;
    logic        expIll;
    logic [31:0] nextAddr;
  } vec_t;

  vec_t vecs[12];
  vec_t sbQ[$];

  int compared   = 0;
  int mismatched = 0;

  // Safety net so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Core comparison: counts every check and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compares all presented decode fields against one expected record.
  task automatic checkDecode(input string tag, input vec_t e);
    checkOutput({tag, "_valid"},   32'(out_valid),   32'd1);
    checkOutput({tag, "_tipo"},    32'(tipo),        32'(e.expTipo));
    checkOutput({tag, "_funct3"},  32'(funct3),      32'(e.expF3));
    checkOutput({tag, "_rs1"},     32'(rs1),         32'(e.expRs1));
    checkOutput({tag, "_rs2"},     32'(rs2),         32'(e.expRs2));
    checkOutput({tag, "_rd"},      32'(rd),          32'(e.expRd));
    checkOutput({tag, "_imm"},     imm,              e.expImm);
    checkOutput({tag, "_pc"},      out_pc,           e.addr);
    checkOutput({tag, "_illegal"}, 32'(out_illegal), 32'(e.expIll));
    checkOutput({tag, "_req"},     32'(imem_req),    32'd0);
  endtask

  // Bounded wait for imem_req, sampled on falling edges.
  task automatic waitForReq(input string tag);
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_req"}, 32'(imem_req), 32'd1);
  endtask

  // Replays one table entry: serve the fetch, check the decode, stall,
  // transfer and check the next request.
  task automatic applyStimulus(input int idx, input vec_t v);
    vec_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    waitForReq(tag);
    checkOutput({tag, "_addr"}, imem_addr, v.addr);
    checkOutput({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    repeat (v.lat - 1) @(negedge clk);
    imem_valid = 1'b1;
    imem_data  = v.instr;
    sbQ.push_back(v);
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = $urandom;
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbQ.pop_front();
    checkDecode(tag, e);
    // Stall: stray memory responses and branch_taken must not disturb HOLD.
    for (int s = 0; s < v.stall; s++) begin
      imem_valid   = 1'b1;
      imem_data    = $urandom;
      branch_taken = 1'b1;
      @(negedge clk);
      checkDecode({tag, "_stall"}, e);
    end
    imem_valid   = 1'b0;
    out_ready    = 1'b1;
    branch_taken = v.br;
    @(negedge clk);
    out_ready    = 1'b0;
    branch_taken = 1'b0;
    checkOutput({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_post_req"},   32'(imem_req),  32'd1);
    checkOutput({tag, "_next_addr"},  imem_addr,      v.nextAddr);
  endtask

  initial begin
    int highs;

    // addr, instr, lat, stall, br, tipo, f3, rs1, rs2, rd, imm, ill, next
    vecs[0]  = '{32'h0000_0000, 32'h0080_A283, 3, 0, 1'b0, 3'b000, 3'b010, 5'd1, 5'd8, 5'd5,  32'h0000_0008, 1'b0, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0004, 32'h4020_81B3, 1, 5, 1'b0, 3'b011, 3'b000, 5'd1, 5'd2, 5'd3,  32'h0000_0000, 1'b0, 32'h0000_0008};
    vecs[2]  = '{32'h0000_0008, 32'h0000_0013, 2, 0, 1'b1, 3'b001, 3'b000, 5'd0, 5'd0, 5'd0,  32'h0000_0000, 1'b1, 32'h0000_000C};
    vecs[3]  = '{32'h0000_000C, 32'hFE11_2E23, 1, 1, 1'b1, 3'b010, 3'b010, 5'd2, 5'd1, 5'd28, 32'hFFFF_FFFC, 1'b0, 32'h0000_0010};
    vecs[4]  = '{32'h0000_0010, 32'hFE20_8CE3, 2, 0, 1'b1, 3'b110, 3'b000, 5'd1, 5'd2, 5'd25, 32'hFFFF_FFF8, 1'b0, 32'h0000_0008};
    vecs[5]  = '{32'h0000_0008, 32'h0000_0013, 1, 0, 1'b0, 3'b001, 3'b000, 5'd0, 5'd0, 5'd0,  32'h0000_0000, 1'b1, 32'h0000_000C};
    vecs[6]  = '{32'h0000_000C, 32'h0080_A283, 1, 0, 1'b1, 3'b000, 3'b010, 5'd1, 5'd8, 5'd5,  32'h0000_0008, 1'b0, 32'h0000_0010};
    vecs[7]  = '{32'h0000_0010, 32'hFE20_8CE3, 1, 2, 1'b0, 3'b110, 3'b000, 5'd1, 5'd2, 5'd25, 32'hFFFF_FFF8, 1'b0, 32'h0000_0014};
    vecs[8]  = '{32'h0000_0014, 32'h0000_0060, 1, 0, 1'b1, 3'b110, 3'b000, 5'd0, 5'd0, 5'd0,  32'h0000_0000, 1'b1, 32'h0000_0018};
    vecs[9]  = '{32'h0000_0018, 32'hFE00_02E3, 4, 0, 1'b1, 3'b110, 3'b000, 5'd0, 5'd0, 5'd5,  32'hFFFF_FFE4, 1'b0, 32'hFFFF_FFFC};
    vecs[10] = '{32'hFFFF_FFFC, 32'h4020_81B3, 1, 0, 1'b0, 3'b011, 3'b000, 5'd1, 5'd2, 5'd3,  32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[11] = '{32'h0000_0000, 32'h0080_A283, 1, 0, 1'b0, 3'b000, 3'b010, 5'd1, 5'd8, 5'd5,  32'h0000_0008, 1'b0, 32'h0000_0004};

    reset        = 1'b1;
    imem_valid   = 1'b0;
    imem_data    = 32'h0;
    out_ready    = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state.
    checkOutput("rst_req",     32'(imem_req),    32'd0);
    checkOutput("rst_addr",    imem_addr,        RESET_PC);
    checkOutput("rst_valid",   32'(out_valid),   32'd0);
    checkOutput("rst_tipo",    32'(tipo),        32'd0);
    checkOutput("rst_rd",      32'(rd),          32'd0);
    checkOutput("rst_imm",     imm,              32'd0);
    checkOutput("rst_pc",      out_pc,           32'd0);
    checkOutput("rst_illegal", 32'(out_illegal), 32'd0);
    checkOutput("rst_error",   32'(fetch_error), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Reset while in FETCH at 0x4; a response arriving in IDLE is dropped.
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    imem_valid = 1'b1;
    imem_data  = 32'h0080_A283;
    checkOutput("rstf_valid", 32'(out_valid), 32'd0);
    checkOutput("rstf_req",   32'(imem_req),  32'd0);
    checkOutput("rstf_addr",  imem_addr,      RESET_PC);
    @(negedge clk);
    imem_valid = 1'b0;
    checkOutput("rstf_drop_valid", 32'(out_valid), 32'd0);
    checkOutput("rstf_refetch_req", 32'(imem_req), 32'd1);
    checkOutput("rstf_refetch_addr", imem_addr,    RESET_PC);
    repeat (3) @(negedge clk);
    checkOutput("rstf_still_idle_valid", 32'(out_valid), 32'd0);

    // Reset while in HOLD discards the presented instruction.
    imem_valid = 1'b1;
    imem_data  = 32'h4020_81B3;
    @(negedge clk);
    imem_valid = 1'b0;
    checkOutput("rsth_valid_before", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rsth_valid", 32'(out_valid), 32'd0);
    checkOutput("rsth_req",   32'(imem_req),  32'd0);
    @(negedge clk);
    checkOutput("rsth_refetch_req",  32'(imem_req), 32'd1);
    checkOutput("rsth_refetch_addr", imem_addr,     RESET_PC);

    // Fetch that never receives a response.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    highs = 0;
`ifdef FETCH_TIMEOUT_EN
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fetch_error) break;
      if (imem_req) highs++;
    end
    checkOutput("to_fetch_cycles", 32'(highs),       32'd8);
    checkOutput("to_error",        32'(fetch_error), 32'd1);
    checkOutput("to_req",          32'(imem_req),    32'd0);
    repeat (5) @(negedge clk);
    checkOutput("to_error_sticky", 32'(fetch_error), 32'd1);
    checkOutput("to_req_parked",   32'(imem_req),    32'd0);
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (imem_req && !fetch_error && !out_valid) highs++;
    end
    checkOutput("wait_req_cycles", 32'(highs),       32'd100);
    checkOutput("wait_error",      32'(fetch_error), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Single-issue instruction fetch and decode stage, sitting directly upstream of the datapath control unit.
- Owns the PC and fetches 32-bit instructions over a variable-latency req/valid instruction-memory interface.
- Decodes each instruction into tipo/funct3/register indices/sign-extended immediate and presents it under a valid/ready handshake.
- Redirects the PC on a taken beq reported by the execute stage.

Parameters:
RESET_PC, 32'h0000_0000, PC after reset (multiple of 4)
TIMEOUT_CYCLES, 64, FETCH wait limit, used only with FETCH_TIMEOUT_EN

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  fetch request, held high in FETCH
imem_addr  output  32  PC of requested word
imem_valid  input  1  imem_data valid this cycle
imem_data  input  32  fetched instruction
out_valid  output  1  decoded instruction presented
out_ready  input  1  downstream accepts (transfer = out_valid & out_ready)
branch_taken  input  1  presented beq resolved taken; sampled only on transfer
tipo  output  3  opcode[6:4]: 000 lw, 010 sw, 011 R-type, 110 beq
funct3  output  3  instr[14:12]
rs1  output  5  instr[19:15]
rs2  output  5  instr[24:20]
rd  output  5  instr[11:7]
imm  output  32  sign-extended immediate
out_pc  output  32  PC of presented instruction
out_illegal  output  1  unsupported opcode
fetch_error  output  1  sticky timeout flag (0 without macro)

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset: state IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; out_valid=0; all decode outputs 0; out_illegal=0; fetch_error=0.
- FSM:
  - IDLE -> FETCH unconditionally after 1 cycle. imem_valid in IDLE is dropped; this flushes any response to a request abandoned by reset.
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid, latch imem_data and the decode fields, set out_pc=pc, out_valid=1, and go to HOLD. imem_valid outside FETCH is ignored.
  - HOLD: out_valid=1 and all outputs stable until transfer. On transfer:
    - pc <= out_pc+imm if branch_taken, tipo==110 and !out_illegal;
    - otherwise pc <= out_pc+4.
    - out_valid <= 0 in the same edge; go to FETCH.
- Latency: response cycle N gives out_valid at N+1. Transfer at cycle M gives imem_req with the new address at M+1.
- Minimum cost is 2 cycles per instruction; no overlap between fetch and decode.
- Immediate generation:
  - lw: {{20{i[31]}},i[31:20]}
  - sw: {{20{i[31]}},i[31:25],i[11:7]}
  - beq: {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}
  - R-type: 0
- out_illegal=1 when opcode[1:0]!=2'b11 or tipo is not in {000,010,011,110}. In that case imm=0; the word is still presented; branch_taken is ignored.
- PC arithmetic is modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000). Branch target aligned because imm[0]=0.
- branch_taken without transfer has no effect.
- Reset mid-FETCH or mid-HOLD discards the instruction and returns to IDLE with RESET_PC.
- Decode fields are raw bit slices regardless of format; downstream ignores unused fields.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- With macro: counter cleared on entry to FETCH, incremented each FETCH cycle without imem_valid. On reaching TIMEOUT_CYCLES: fetch_error <= 1 (sticky), imem_req <= 0, FSM parks in a HALT state. Only reset exits HALT.
- Without macro: no counter, no HALT state, fetch_error tied 0, FETCH waits indefinitely.

Test Plan:
- Reset, memory returns 0x0080A283 after 3 cycles -> imem_addr=0x0; out_valid 1 cycle after imem_valid with tipo=000, funct3=010, rs1=1, rd=5, imm=8, out_pc=0; after transfer next imem_addr=0x4.
- 0x402081B3 at PC 0x4 with out_ready=0 for 5 cycles -> outputs stable, imem_req=0 throughout; tipo=011, funct3=000, rs1=1, rs2=2, rd=3, imm=0; after ready next fetch address is 0x8.
- 0xFE208CE3 (beq x1,x2,-8) at PC 0x10: transfer with branch_taken=1 -> imm=0xFFFFFFF8, next imem_addr=0x8. Repeat with branch_taken=0 -> next imem_addr=0x14.
- 0x00000013 (addi) -> out_illegal=1, imm=0; branch_taken=1 on transfer ignored, next address is PC+4.
- Reset asserted while in FETCH with a response arriving next cycle -> response dropped, out_valid stays 0, re-fetch from RESET_PC.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, imem_valid never asserted -> fetch_error=1 after 8 FETCH cycles, imem_req=0, held until reset. Without macro -> imem_req stays 1, fetch_error=0.
